// File: rtl/axis_ask_uart_rx_pkg.sv
// axis_ask_uart_rx_pkg: shared RX state encoding, frame constants and pointer-width helper
package axis_ask_uart_rx_pkg;
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_BREAK = 3'd4;
    localparam int DATA_BITS   = 8;
    localparam int SYNC_STAGES = 2;
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
endpackage

// File: rtl/axis_byte_fifo.sv
// axis_byte_fifo: byte FIFO with registered first-word-fall-through AXI-Stream output
// Ports: clk, rst (sync, active-high); push/din write side with full flag;
// o_tdata/o_tvalid/o_tready AXI-S master; level = bytes held, zero-extended to 16 bits.
module axis_byte_fifo
    import axis_ask_uart_rx_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic [7:0]  din,
    output logic        full,
    output logic [7:0]  o_tdata,
    output logic        o_tvalid,
    input  logic        o_tready,
    output logic [15:0] level
);
    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, rd_next;
    logic [CW-1:0] count, count_next;
    logic          pop, push_ok, valid_next;
    // A push while full is dropped even if a pop happens in the same cycle.
    assign full       = count == CW'(DEPTH);
    assign pop        = o_tvalid && o_tready;
    assign push_ok    = push && !full;
    assign rd_next    = pop ? rd_ptr + AW'(1) : rd_ptr;
    assign count_next = (push_ok && !pop) ? count + CW'(1) :
                        (!push_ok && pop) ? count - CW'(1) : count;
    // The output stage only sees words committed before this edge, which gives
    // the one-cycle lag from push to o_tvalid.
    assign valid_next = pop ? count > CW'(1) : count != '0;
    assign level      = 16'(count);
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            o_tvalid <= 1'b0;
            o_tdata  <= '0;
        end else begin
            wr_ptr   <= push_ok ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr   <= rd_next;
            count    <= count_next;
            o_tvalid <= valid_next;
            o_tdata  <= valid_next ? mem[rd_next] : o_tdata;
        end
    end
endmodule

// File: rtl/axis_ask_uart_rx.sv
// axis_ask_uart_rx: ASK UART 8N1 receiver delivering bytes on an AXI-Stream master port
// Ports: clk, rst (sync, active-high); ask_rx = async ASK amplitude code;
// o_tdata/o_tvalid/o_tready AXI-S byte output; fifo_level = bytes buffered;
// frame_err / overrun = one-cycle pulses for bad stop bit / byte dropped on full FIFO.
module axis_ask_uart_rx
    import axis_ask_uart_rx_pkg::*;
#(
    parameter int ask_rx_length = 2,
    parameter int ask_threshold = 2,
    parameter int RX_SIZE       = 16,
    parameter int clkdiv_rx     = 100
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ask_rx_length-1:0] ask_rx,
    output logic [7:0]               o_tdata,
    output logic                     o_tvalid,
    input  logic                     o_tready,
    output logic [15:0]              fifo_level,
    output logic                     frame_err,
    output logic                     overrun
);
    localparam logic [15:0] HALF_LAST = 16'(clkdiv_rx / 2 - 1);
    localparam logic [15:0] BIT_LAST  = 16'(clkdiv_rx - 1);
    logic [SYNC_STAGES-1:0] sync;
    logic [2:0]             state;
    logic [15:0]            cnt;
    logic [2:0]             bit_idx;
    logic [7:0]             shreg;
    logic                   line, tick, full, push;
    // Synchronizer presets to mark so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) sync <= '1;
        else     sync <= {sync[SYNC_STAGES-2:0], ask_rx >= ask_rx_length'(ask_threshold)};
    end
    assign line = sync[SYNC_STAGES-1];
    assign tick = cnt == '0;
    assign push = state == ST_STOP && tick && line && !full;
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            case (state)
                ST_IDLE: if (!line) begin
                    state <= ST_START;
                    cnt   <= HALF_LAST;
                end
                ST_START: if (!tick) cnt <= cnt - 16'd1;
                else if (line) state <= ST_IDLE;
                else begin
                    state   <= ST_DATA;
                    cnt     <= BIT_LAST;
                    bit_idx <= '0;
                end
                ST_DATA: if (!tick) cnt <= cnt - 16'd1;
                else begin
                    shreg   <= {line, shreg[7:1]};
                    cnt     <= BIT_LAST;
                    bit_idx <= bit_idx + 3'd1;
                    if (bit_idx == 3'(DATA_BITS - 1)) state <= ST_STOP;
                end
                ST_STOP: if (!tick) cnt <= cnt - 16'd1;
                else if (line) begin
                    overrun <= full;
                    state   <= ST_IDLE;
                end else begin
                    frame_err <= 1'b1;
                    state     <= ST_BREAK;
                end
                // Held-low line must return to mark before a new start is accepted.
                ST_BREAK: if (line) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end
    axis_byte_fifo #(.DEPTH(RX_SIZE)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .din      (shreg),
        .full     (full),
        .o_tdata  (o_tdata),
        .o_tvalid (o_tvalid),
        .o_tready (o_tready),
        .level    (fifo_level)
    );
endmodule

// File: tb/tb_axis_ask_uart_rx.sv
// tb_axis_ask_uart_rx: directed self-checking bench for axis_ask_uart_rx
module tb_axis_ask_uart_rx;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        o_tready = 1'b1;
    logic [1:0]  ask_rx = 2'd3;
    logic [7:0]  o_tdata;
    logic        o_tvalid, frame_err, overrun;
    logic [15:0] fifo_level;
    int cyc = 0, n_cmp = 0, n_err = 0;
    logic [7:0] got [64];
    int widx = 0, vcnt = 0, vrise = 0, lrise = 0, ferr_cnt = 0, ferr_cyc = 0, ovr_cnt = 0, hold_bad = 0;
    logic        pv = 1'b0, pr = 1'b0;
    logic [7:0]  pd = '0;
    logic [15:0] plvl = '0;

    axis_ask_uart_rx #(
        .ask_rx_length (2),
        .ask_threshold (2),
        .RX_SIZE       (4),
        .clkdiv_rx     (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ask_rx     (ask_rx),
        .o_tdata    (o_tdata),
        .o_tvalid   (o_tvalid),
        .o_tready   (o_tready),
        .fifo_level (fifo_level),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) pv <= 1'b0;
        else begin
            if (pv && !pr && (!o_tvalid || o_tdata != pd)) hold_bad <= hold_bad + 1;
            if (o_tvalid && !pv) vrise <= cyc;
            if (o_tvalid) vcnt <= vcnt + 1;
            if (o_tvalid && o_tready) begin
                got[widx] <= o_tdata;
                widx <= widx + 1;
            end
            if (fifo_level != 0 && plvl == 0) lrise <= cyc;
            if (frame_err) begin
                ferr_cnt <= ferr_cnt + 1;
                ferr_cyc <= cyc;
            end
            if (overrun) ovr_cnt <= ovr_cnt + 1;
            pv <= o_tvalid;
            pr <= o_tready;
            pd <= o_tdata;
        end
        plvl <= fifo_level;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input logic [1:0] mk, input logic [1:0] sp);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            ask_rx = f[i] ? mk : sp;
            tick(16);
        end
    endtask

    initial begin
        int t0, w0, f0, o0, v0;
        logic [7:0] pat [8];
        pat = '{8'h00, 8'hFF, 8'h81, 8'h7E, 8'h12, 8'h34, 8'hC5, 8'h6B};
        tick(3);
        chk("rst_tvalid", 32'(o_tvalid), 0);
        chk("rst_tdata", 32'(o_tdata), 0);
        chk("rst_level", 32'(fifo_level), 0);
        chk("rst_ferr", 32'(frame_err), 0);
        chk("rst_ovr", 32'(overrun), 0);
        rst = 1'b0;
        tick(10);
        // 0x55 latency
        w0 = widx; f0 = ferr_cnt; o0 = ovr_cnt; v0 = vcnt; t0 = cyc + 1;
        send_frame(8'h55, 1'b1, 2'd3, 2'd0);
        tick(20);
        chk("t1_push_cyc", 32'(lrise - t0), 154);
        chk("t1_valid_cyc", 32'(vrise - t0), 155);
        chk("t1_valid_len", 32'(vcnt - v0), 1);
        chk("t1_nbytes", 32'(widx - w0), 1);
        chk("t1_data", 32'(got[w0]), 32'h55);
        chk("t1_ferr", 32'(ferr_cnt - f0), 0);
        chk("t1_ovr", 32'(ovr_cnt - o0), 0);
        // bad stop bit, held-low line, recovery
        w0 = widx; f0 = ferr_cnt; t0 = cyc + 1;
        send_frame(8'hA3, 1'b0, 2'd3, 2'd0);
        tick(200);
        chk("t2_ferr_cnt", 32'(ferr_cnt - f0), 1);
        chk("t2_ferr_cyc", 32'(ferr_cyc - t0), 154);
        chk("t2_nopush", 32'(widx - w0), 0);
        chk("t2_level", 32'(fifo_level), 0);
        ask_rx = 2'd3;
        tick(10);
        send_frame(8'h3C, 1'b1, 2'd3, 2'd0);
        tick(20);
        chk("t2_next_n", 32'(widx - w0), 1);
        chk("t2_next_data", 32'(got[w0]), 32'h3C);
        chk("t2_ferr_once", 32'(ferr_cnt - f0), 1);
        // start glitch
        w0 = widx; f0 = ferr_cnt; o0 = ovr_cnt;
        ask_rx = 2'd1;
        tick(4);
        ask_rx = 2'd3;
        tick(40);
        chk("t3_nobyte", 32'(widx - w0), 0);
        chk("t3_level", 32'(fifo_level), 0);
        chk("t3_ferr", 32'(ferr_cnt - f0), 0);
        chk("t3_ovr", 32'(ovr_cnt - o0), 0);
        send_frame(8'h5A, 1'b1, 2'd3, 2'd0);
        tick(20);
        chk("t3_after_n", 32'(widx - w0), 1);
        chk("t3_after_data", 32'(got[w0]), 32'h5A);
        // overrun
        w0 = widx; o0 = ovr_cnt;
        o_tready = 1'b0;
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 2'd3, 2'd0);
        tick(20);
        chk("t4_level", 32'(fifo_level), 4);
        chk("t4_ovr", 32'(ovr_cnt - o0), 1);
        chk("t4_head_valid", 32'(o_tvalid), 1);
        chk("t4_head_data", 32'(o_tdata), 1);
        o_tready = 1'b1;
        tick(10);
        chk("t4_drain_n", 32'(widx - w0), 4);
        for (int i = 0; i < 4; i++) chk("t4_drain_data", 32'(got[w0 + i]), 32'(i + 1));
        chk("t4_level_empty", 32'(fifo_level), 0);
        // backpressure, threshold-edge codes 2/1
        w0 = widx; f0 = ferr_cnt; o0 = ovr_cnt;
        fork
            for (int i = 0; i < 8; i++) send_frame(pat[i], 1'b1, 2'd2, 2'd1);
            repeat (1320) begin
                tick(1);
                o_tready = ~o_tready;
            end
        join
        o_tready = 1'b1;
        ask_rx = 2'd3;
        tick(10);
        chk("t5_n", 32'(widx - w0), 8);
        for (int i = 0; i < 8; i++) chk("t5_data", 32'(got[w0 + i]), 32'(pat[i]));
        chk("t5_hold", 32'(hold_bad), 0);
        chk("t5_flags", 32'(ferr_cnt - f0 + ovr_cnt - o0), 0);
        // reset mid-DATA
        o_tready = 1'b0;
        send_frame(8'h96, 1'b1, 2'd3, 2'd0);
        tick(20);
        chk("t6_pre_valid", 32'(o_tvalid), 1);
        chk("t6_pre_data", 32'(o_tdata), 32'h96);
        ask_rx = 2'd0;
        tick(72);
        rst = 1'b1;
        tick(1);
        chk("t6_rst_tvalid", 32'(o_tvalid), 0);
        chk("t6_rst_tdata", 32'(o_tdata), 0);
        chk("t6_rst_level", 32'(fifo_level), 0);
        chk("t6_rst_flags", 32'({frame_err, overrun}), 0);
        rst = 1'b0;
        ask_rx = 2'd3;
        tick(200);
        chk("t6_no_partial", 32'(fifo_level), 0);
        w0 = widx;
        o_tready = 1'b1;
        send_frame(8'hFF, 1'b1, 2'd3, 2'd0);
        tick(20);
        chk("t6_next_n", 32'(widx - w0), 1);
        chk("t6_next_data", 32'(got[w0]), 32'hFF);
        chk("final_hold", 32'(hold_bad), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
